fetch_unit_rv32i: RTL
=====================

# fetch_unit_rv32i

Program-counter and instruction-fetch stage for the RV32I core. It holds the architectural PC and supplies `PCnew` (PC+4) to the brancher. It fetches the instruction at PC over a req/ack instruction-memory handshake and presents it to decode with a valid/ready handshake. On retire it loads the brancher's `PCin` as the next PC and traps misaligned targets.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000, PC value loaded on reset.

Ports:
- `clock`  in  1  system clock, rising-edge.
- `nreset`  in  1  asynchronous, active-low reset.
- `PCin`  in  32  next PC selected by the brancher; sampled only on retire.
- `PCnew`  out  32  PC+4, fed to the brancher.
- `PC`  out  32  current PC; also drives branch-target computation.
- `imem_req`  out  1  instruction-memory request.
- `imem_addr`  out  32  fetch address; equals `PC` whenever `imem_req`=1.
- `imem_ack`  in  1  memory has `imem_rdata` valid this cycle.
- `imem_rdata`  in  32  instruction word.
- `instr`  out  32  latched instruction to decode.
- `instr_valid`  out  1  `instr` is valid.
- `instr_ready`  in  1  core has executed `instr`; `PCin` is final this cycle.
- `misalign`  out  1  sticky flag: a retired instruction produced a `PCin` with bits [1:0] != 0.
- `bad_pc`  out  32  offending `PCin` captured on the misalign trap.
- `instret`  out  32  retired-instruction counter.

## Operation
- The FSM has four states: BOOT, FETCH, HOLD, TRAP.
- BOOT: the reset state. `imem_req`=0. Moves to FETCH unconditionally on the first rising edge after `nreset` rises.
- FETCH: `imem_req`=1, `imem_addr`=`PC`.
  - If `imem_ack`=1: `instr`<=`imem_rdata`, then go to HOLD.
  - Otherwise remain in FETCH with the request and address held stable.
- HOLD: `instr_valid`=1 and `imem_req`=0. If `instr_ready`=1 (retire):
  - `instret`<=`instret`+1, wrapping at 2^32.
  - If `PCin`[1:0]==0: `PC`<=`PCin`, then go to FETCH.
  - Else: `misalign`<=1, `bad_pc`<=`PCin`, `PC` unchanged, then go to TRAP.
- HOLD with `instr_ready`=0: everything holds, and `instr` stays stable.
- TRAP: absorbing state. `imem_req`=0 and `instr_valid`=0. Only `nreset` exits it.
- `PCnew` = `PC` + 32'd4, combinational, modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
- `instr_valid` is 1 only in HOLD and is a registered state decode.
- `imem_rdata` is ignored unless the state is FETCH and `imem_ack`=1. `imem_ack` outside FETCH is ignored.
- `instr_ready` outside HOLD is ignored.
- A misaligned `RESET_PC` is not checked.

## Timing
- While `nreset`=0, asynchronously and immediately:
  - state=BOOT, `PC`=`RESET_PC`, `PCnew`=`RESET_PC`+4
  - `imem_req`=0, `imem_addr`=`RESET_PC`
  - `instr`=0, `instr_valid`=0
  - `misalign`=0, `bad_pc`=0, `instret`=0
- After release: edge 1 enters FETCH, and the request is visible in the following cycle.
- Minimum instruction cost is 2 cycles: FETCH with same-cycle ack, then HOLD with `instr_ready`=1. Each memory wait cycle and each decode stall cycle adds 1.
- Fetch latency: if ack arrives in FETCH cycle N, `instr_valid`=1 in cycle N+1.
- The retire edge updates `PC`, `instret` and the state together. The new `PCnew` is visible the cycle after retire.
- Reset asserted mid-request (FETCH with ack pending) or mid-HOLD aborts immediately: all registers return to reset values and no retire is counted. A late `imem_ack` arriving in BOOT is ignored.

## Test plan
- Reset/boot: hold `nreset`=0 for 3 cycles with `RESET_PC`=0x0000_0100, then release -> during reset all outputs at reset values and `PCnew`=0x104. `imem_req`=1 with `imem_addr`=0x100 exactly one edge after release.
- Zero-wait sequential: ack in the same cycle with words 0x00000013 and 0x00100093, `instr_ready`=1, `PCin`=`PCnew` -> one instruction per 2 cycles, addresses 0x100 then 0x104, `instret` reaches 2.
- Wait states and stall: delay ack 3 cycles, then hold `instr_ready`=0 for 4 cycles ->
  - request and address stable during the wait
  - `instr` stable and `instr_valid`=1 during the stall
  - `instret` unchanged until `instr_ready` rises
- Taken branch: in HOLD at PC=0x108, drive `PCin`=0x0000_0040 with `instr_ready`=1 -> next `imem_addr`=0x40 and `PCnew`=0x44.
- Misaligned target: retire with `PCin`=0x0000_0102 -> `misalign`=1, `bad_pc`=0x102, `PC` unchanged, `instret` incremented, `imem_req` stays 0 for 10+ cycles until reset.
- Wrap and reset abort:
  - `PCin`=0xFFFF_FFFC -> `PCnew`=0x0000_0000, and the next fetch after retire is at 0x0.
  - Assert `nreset` while FETCH waits on ack -> `imem_req` drops in the same cycle; a stale ack during BOOT does not set `instr_valid`.

Source files
------------

// File: rtl/fetch_unit_rv32i.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_unit_rv32i
//  Description : Program-counter and instruction-fetch stage for an RV32I
//                core. Holds the architectural PC and fetches the word at PC
//                over a req/ack instruction-memory handshake. It presents the
//                word to decode with a valid/ready handshake. On retire it
//                loads the brancher's next PC, or traps if that PC is
//                misaligned.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clock        in   1   system clock, rising edge
//    nreset       in   1   asynchronous active-low reset
//    PCin         in  32   next PC from the brancher, sampled on retire
//    PCnew        out 32   PC + 4 (combinational, wraps modulo 2^32)
//    PC           out 32   current architectural PC
//    imem_req     out  1   instruction-memory request (FETCH only)
//    imem_addr    out 32   fetch address, always equal to PC
//    imem_ack     in   1   imem_rdata is valid this cycle
//    imem_rdata   in  32   instruction word from memory
//    instr        out 32   latched instruction presented to decode
//    instr_valid  out  1   instr is valid (registered HOLD decode)
//    instr_ready  in   1   core has executed instr; PCin is final
//    misalign     out  1   sticky misaligned-target trap flag
//    bad_pc       out 32   offending PCin captured by the trap
//    instret      out 32   retired-instruction counter (wraps)
// ============================================================================
module fetch_unit_rv32i #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic [31:0] PCin,
    output logic [31:0] PCnew,
    output logic [31:0] PC,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        misalign,
    output logic [31:0] bad_pc,
    output logic [31:0] instret
);

    // ------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------
    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_TRAP  = 2'd3;

    localparam logic [31:0] C_PC_STEP = 32'd4;

    logic [1:0]  state_q;
    logic [1:0]  state_d;
    logic        valid_q;

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] instr_q;
    logic [31:0] instr_d;
    logic [31:0] instret_q;
    logic [31:0] instret_d;
    logic        misalign_q;
    logic        misalign_d;
    logic [31:0] bad_pc_q;
    logic [31:0] bad_pc_d;

    // Qualified handshake events. Acks outside FETCH and ready outside
    // HOLD never reach any register, so a stale ack in BOOT is harmless.
    logic w_fetch_done;
    logic w_retire;
    logic w_target_ok;

    assign w_fetch_done = (state_q == S_FETCH) && imem_ack;
    assign w_retire     = (state_q == S_HOLD) && instr_ready;
    assign w_target_ok  = (PCin[1:0] == 2'b00);

    // ------------------------------------------------------------------
    // FSM: state register
    // instr_valid is registered alongside the state so decode sees a
    // clean flop output rather than a decode of the state bits.
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= S_BOOT;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d == S_HOLD);
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT:  state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (instr_ready) begin
                    state_d = w_target_ok ? S_FETCH : S_TRAP;
                end
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_BOOT;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // imem_req is a pure decode of the state register, so it drops the
    // moment nreset forces the state back to BOOT.
    // ------------------------------------------------------------------
    always_comb begin
        imem_req    = (state_q == S_FETCH);
        instr_valid = valid_q;
        imem_addr   = pc_q;
        PC          = pc_q;
        PCnew       = pc_q + C_PC_STEP;
        instr       = instr_q;
        misalign    = misalign_q;
        bad_pc      = bad_pc_q;
        instret     = instret_q;
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        instret_d  = instret_q;
        misalign_d = misalign_q;
        bad_pc_d   = bad_pc_q;

        if (w_fetch_done) begin
            instr_d = imem_rdata;
        end

        if (w_retire) begin
            // A retire is counted even when its target traps.
            instret_d = instret_q + 32'd1;
            if (w_target_ok) begin
                pc_d = PCin;
            end else begin
                // PC is left pointing at the instruction that produced
                // the bad target so a handler can find it.
                misalign_d = 1'b1;
                bad_pc_d   = PCin;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            instret_q  <= 32'd0;
            misalign_q <= 1'b0;
            bad_pc_q   <= 32'd0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instret_q  <= instret_d;
            misalign_q <= misalign_d;
            bad_pc_q   <= bad_pc_d;
        end
    end

endmodule
`default_nettype wire
